// File: rtl/skewed_output_buffer_pkg.sv
// skewed_output_buffer_pkg: sizing defaults and width helpers shared by the skewed output buffer
package skewed_output_buffer_pkg;
    localparam int ARRAYWIDTH = 4;
    localparam int DATASIZE   = 8;
    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction
endpackage

// File: rtl/skewed_output_buffer_delay.sv
// skew_delay_line: DEPTH-stage shift pipe carrying a {valid, bank, row} tag; DEPTH=0 is a wire
module skew_delay_line
    import skewed_output_buffer_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q_o = d_i;
        end else begin : g_pipe
            logic [W-1:0] pipe_q [DEPTH];
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_q <= '{default: '0};
                end else begin
                    pipe_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign q_o = pipe_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/skewed_output_buffer.sv
// skewed_output_buffer: ping-pong buffer that de-skews systolic-array result tiles and drains them row by row
module skewed_output_buffer
    import skewed_output_buffer_pkg::*;
#(
    parameter int COLS  = ARRAYWIDTH,
    parameter int ROWS  = ARRAYWIDTH,
    parameter int ACC_W = 2*DATASIZE,
    localparam int RW   = row_w(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [COLS*ACC_W-1:0] in_res,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COLS*ACC_W-1:0] out_data,
    output logic [RW-1:0]         out_row,
    output logic                  out_last,
    output logic                  err_drop
);
    localparam int TW = RW + 2;
    localparam int AW = $clog2(2*ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);

    logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [RW-1:0]         wr_row_q, wr_row_d, rd_row_q, rd_row_d;
    logic [1:0]            busy_q, busy_d, full_q, full_d;
    logic                  err_q, err_d;
    logic                  accept, beat, last_beat;
    logic                  lt_v, lt_b;
    logic [RW-1:0]         lt_r;
    logic [TW-1:0]         tag [COLS];
    logic [AW-1:0]         rd_addr;
    logic [COLS*ACC_W-1:0] rd_data;

    // a started tile is never stalled; only a new tile waits for its bank to drain
    assign in_ready  = (wr_row_q != '0) || !busy_q[wr_bank_q];
    assign accept    = in_valid && in_ready;
    assign out_valid = full_q[rd_bank_q];
    assign beat      = out_valid && out_ready;
    assign last_beat = beat && (rd_row_q == LAST_ROW);
    assign out_data  = out_valid ? rd_data : '0;
    assign out_row   = rd_row_q;
    assign out_last  = out_valid && (rd_row_q == LAST_ROW);
    assign err_drop  = err_q;
    assign rd_addr   = AW'(rd_bank_q) * AW'(ROWS) + AW'(rd_row_q);
    assign {lt_v, lt_b, lt_r} = tag[COLS-1];

    generate
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [ACC_W-1:0] mem_q [2*ROWS];
            logic [AW-1:0]    wr_addr;
            skew_delay_line #(.DEPTH(c), .W(TW)) u_skew (
                .clk (clk),
                .rst (rst),
                .d_i ({accept, wr_bank_q, wr_row_q}),
                .q_o (tag[c])
            );
            assign wr_addr = AW'(tag[c][RW]) * AW'(ROWS) + AW'(tag[c][RW-1:0]);
            always_ff @(posedge clk) begin
                if (tag[c][TW-1]) mem_q[wr_addr] <= in_res[c*ACC_W +: ACC_W];
            end
            assign rd_data[c*ACC_W +: ACC_W] = mem_q[rd_addr];
        end
    endgenerate

    always_comb begin
        wr_bank_d = accept ? wr_bank_q ^ (wr_row_q == LAST_ROW) : wr_bank_q;
        wr_row_d  = !accept ? wr_row_q : (wr_row_q == LAST_ROW) ? '0 : wr_row_q + RW'(1);
        rd_bank_d = last_beat ? !rd_bank_q : rd_bank_q;
        rd_row_d  = !beat ? rd_row_q : last_beat ? '0 : rd_row_q + RW'(1);
        err_d     = err_q || (in_valid && !in_ready);
        busy_d    = busy_q;
        full_d    = full_q;
        if (accept && wr_row_q == '0) busy_d[wr_bank_q] = 1'b1;
        if (lt_v && lt_r == LAST_ROW) full_d[lt_b] = 1'b1;
        if (last_beat) begin
            busy_d[rd_bank_q] = 1'b0;
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_row_q  <= '0;
            busy_q    <= '0;
            full_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_row_q  <= rd_row_d;
            busy_q    <= busy_d;
            full_q    <= full_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_skewed_output_buffer.sv
// tb_skewed_output_buffer: directed scoreboard bench for the skewed output buffer
module tb_skewed_output_buffer;
    localparam int COLS = 4, ROWS = 4, ACC_W = 16, DW = COLS*ACC_W;
    typedef struct { logic [DW-1:0] d; logic [1:0] r; logic l; } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last, err_drop;
    logic [DW-1:0] in_res = '0, out_data;
    logic [1:0] out_row;
    logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_last, b_err_drop;
    logic [31:0] b_in_res = '0, b_out_data;
    logic b_out_row;

    int checks = 0, errors = 0;
    exp_t sb[$];
    bit hv[COLS];
    int hid[COLS];
    int next_id = 0, mrow = 0;
    bit stalled = 1'b0;
    logic [DW-1:0] held_d;
    logic [1:0] held_r;

    always #5 clk = ~clk;

    skewed_output_buffer #(.COLS(COLS), .ROWS(ROWS), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_last(out_last), .err_drop(err_drop)
    );

    skewed_output_buffer #(.COLS(2), .ROWS(1), .ACC_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_res(b_in_res),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_row(b_out_row),
        .out_last(b_out_last), .err_drop(b_err_drop)
    );

    function automatic logic [15:0] elem(input int id, input int c);
        return 16'(id*16 + c);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // er/eov: expected in_ready/out_valid this cycle, 2 = don't care
    task automatic step(input bit v, input bit ordy, input int er, input int eov);
        exp_t e;
        for (int c = COLS-1; c > 0; c--) begin
            hv[c] = hv[c-1];
            hid[c] = hid[c-1];
        end
        hv[0] = v;
        hid[0] = next_id;
        for (int c = 0; c < COLS; c++) in_res[c*ACC_W +: ACC_W] = hv[c] ? elem(hid[c], c) : 16'($urandom);
        in_valid = v;
        out_ready = ordy;
        @(negedge clk);
        if (er != 2) chk("in_ready", in_ready, 64'(er));
        if (eov != 2) chk("out_valid", out_valid, 64'(eov));
        if (v && er == 1) begin
            for (int c = 0; c < COLS; c++) e.d[c*ACC_W +: ACC_W] = elem(next_id, c);
            e.r = 2'(mrow);
            e.l = (mrow == ROWS-1);
            sb.push_back(e);
            mrow = (mrow + 1) % ROWS;
            next_id++;
        end else begin
            hv[0] = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            step(1'b0, rnd ? 1'($urandom) : 1'b1, 2, 2);
            n++;
        end
        chk("drain_done", 64'(sb.size()), 0);
        step(1'b0, 1'b1, 2, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held_d);
                chk("stall_row", out_row, held_r);
            end
            if (out_valid && out_ready) begin
                chk("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat_data", out_data, e.d);
                    chk("beat_row", out_row, e.r);
                    chk("beat_last", out_last, e.l);
                end
            end
            stalled = out_valid && !out_ready;
            held_d = out_data;
            held_r = out_row;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err_drop", err_drop, 0);
        chk("rst_b_in_ready", b_in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // single tile: out_valid rises in the cycle after edge t0+6
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1, 0);
        for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 2, 0);
        step(1'b0, 1'b1, 2, 1);
        drain(1'b0);

        // two back-to-back tiles with the consumer stalled, then an overflow wave
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1, 2);
        chk("err_before_ovf", err_drop, 0);
        step(1'b1, 1'b0, 0, 2);
        step(1'b0, 1'b0, 0, 1);
        chk("err_after_ovf", err_drop, 1);
        for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 0, 1);
        drain(1'b0);

        // overlapped load and drain with random backpressure
        for (int k = 0; k < 4; k++) step(1'b1, 1'($urandom), 1, 2);
        for (int j = 0; j < 4; j++) step(1'b0, 1'($urandom), 2, 2);
        for (int k = 0; k < 4; k++) step(1'b1, 1'($urandom), 1, 2);
        drain(1'b1);

        // reset in the middle of a tile
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1, 2);
        step(1'b0, 1'b1, 2, 2);
        step(1'b0, 1'b1, 2, 2);
        chk("err_pre_rst", err_drop, 1);
        rst = 1'b1;
        step(1'b0, 1'b1, 2, 2);
        rst = 1'b0;
        sb.delete();
        mrow = 0;
        for (int c = 0; c < COLS; c++) hv[c] = 1'b0;
        step(1'b0, 1'b1, 1, 0);
        chk("err_post_rst", err_drop, 0);

        // fresh tiles in banks 0 and 1; tile 3 offered on bank 0's final beat
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1, 2);
        for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 0, 1);
        chk("err_before_collide", err_drop, 0);
        for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 2, 1);
        step(1'b1, 1'b1, 0, 1);
        chk("err_collide", err_drop, 1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1, 2);
        drain(1'b0);
        in_valid = 1'b0;

        // ROWS=1, COLS=2 instance: one beat per wave
        b_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b_in_valid = 1'b1;
            b_in_res = {16'hBEEF, 16'(16'hA0 + i)};
            @(negedge clk);
            chk("b_in_ready", b_in_ready, 1);
            chk("b_idle", b_out_valid, 0);
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            b_in_res = {16'(16'hB0 + i), 16'h0};
            @(posedge clk); #1;
            @(negedge clk);
            chk("b_valid", b_out_valid, 1);
            chk("b_data", b_out_data, {16'(16'hB0 + i), 16'(16'hA0 + i)});
            chk("b_row", b_out_row, 0);
            chk("b_last", b_out_last, 1);
            @(posedge clk); #1;
        end
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        b_in_res = {16'hDEAD, 16'h00C0};
        @(negedge clk);
        chk("b_rdy_bank0", b_in_ready, 1);
        @(posedge clk); #1;
        b_in_res = {16'h00C1, 16'h00D0};
        @(negedge clk);
        chk("b_rdy_bank1", b_in_ready, 1);
        @(posedge clk); #1;
        b_in_res = {16'h00D1, 16'hDEAD};
        @(negedge clk);
        chk("b_rdy_both_busy", b_in_ready, 0);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_err", b_err_drop, 1);
        chk("b_first_valid", b_out_valid, 1);
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        @(negedge clk);
        chk("b_data_c", b_out_data, 32'h00C1_00C0);
        chk("b_last_c", b_out_last, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_data_d", b_out_data, 32'h00D1_00D0);
        chk("b_valid_d", b_out_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_drained", b_out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
